// File: rtl/ad7903_acq_ctrl_if.sv
// Signal bundle between the AD7903 acquisition sequencer, the SPI master it
// drives and the downstream sample consumer.
interface ad7903_acq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [2:0]            i_spi_state;
  logic [DATA_WIDTH-1:0] i_miso_data;
  logic                  o_cnv;
  logic                  o_spi_start;
  logic [DATA_WIDTH-1:0] o_adc_data;
  logic                  o_adc_valid;
  logic                  o_overrun;
  logic                  o_timeout;
  logic                  o_busy;

  modport master (
    input  i_spi_state, i_miso_data,
    output o_cnv, o_spi_start, o_adc_data, o_adc_valid, o_overrun, o_timeout, o_busy
  );

  modport slave (
    output i_spi_state, i_miso_data,
    input  o_cnv, o_spi_start, o_adc_data, o_adc_valid, o_overrun, o_timeout, o_busy
  );
endinterface

// File: rtl/ad7903_acq_ctrl.sv
// AD7903 sample-rate sequencer: periodic CNV, SPI read kick-off, result capture
// and power-of-two averaging of the signed conversion results.
module ad7903_acq_ctrl #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SAMPLE_PERIOD = 200,
  parameter int unsigned CONV_TIME     = 100,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  ad7903_acq_ctrl_if.master bus
);

  localparam int unsigned PW   = $clog2(SAMPLE_PERIOD);
  localparam int unsigned CMAX = (CONV_TIME > TIMEOUT) ? CONV_TIME : TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned AW   = DATA_WIDTH + AVG_LOG2;
  localparam int unsigned NW   = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [NW-1:0] N_LAST = NW'((2 ** AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  state_t                 state_q;
  logic [PW-1:0]          per_q;
  logic [CW-1:0]          cyc_q;
  logic signed [AW-1:0]   acc_q;
  logic [NW-1:0]          n_q;
  logic                   cnv_q;
  logic                   start_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   valid_q;
  logic                   ovr_q;
  logic                   to_q;
  logic                   busy_q;

  logic                   tick_c;
  logic [CW-1:0]          cyc_inc_c;
  logic                   to_hit_c;
  logic signed [DATA_WIDTH-1:0] smp_c;
  logic signed [AW-1:0]   smp_ext_c;
  logic signed [AW-1:0]   sum_c;

  assign tick_c    = i_en && (per_q == '0);
  assign cyc_inc_c = cyc_q + CW'(1);
  assign to_hit_c  = (cyc_inc_c == CW'(TIMEOUT));
  assign smp_c     = bus.i_miso_data;
  assign smp_ext_c = AW'(smp_c);
  assign sum_c     = acc_q + smp_ext_c;

  // Sample-period counter; parked at 0 while disabled so enabling ticks at once
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      per_q <= '0;
    end else if (!i_en || (per_q == PW'(SAMPLE_PERIOD - 1))) begin
      per_q <= '0;
    end else begin
      per_q <= per_q + PW'(1);
    end
  end

  // Acquisition FSM; cyc_q times CNV in CONV and the SPI watchdog in the waits
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      cnv_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;

      if (tick_c && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (!i_en) begin
            acc_q <= '0;
            n_q   <= '0;
          end
          if (tick_c) begin
            state_q <= S_CONV;
            cnv_q   <= 1'b1;
            busy_q  <= 1'b1;
            cyc_q   <= '0;
          end
        end
        S_CONV: begin
          if (cyc_q == CW'(CONV_TIME - 1)) begin
            state_q <= S_START;
            cnv_q   <= 1'b0;
            start_q <= 1'b1;
          end else begin
            cyc_q <= cyc_inc_c;
          end
        end
        S_START: begin
          state_q <= S_WAIT_BUSY;
          cyc_q   <= '0;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          // Watchdog wins over a same-cycle SPI state change
          if (to_hit_c) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            to_q    <= 1'b1;
          end else begin
            cyc_q <= cyc_inc_c;
            if ((state_q == S_WAIT_BUSY) && (bus.i_spi_state != 3'd0)) begin
              state_q <= S_WAIT_DONE;
            end else if ((state_q == S_WAIT_DONE) && (bus.i_spi_state == 3'd0)) begin
              state_q <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (n_q == N_LAST) begin
            data_q  <= DATA_WIDTH'(sum_c >>> AVG_LOG2);
            valid_q <= 1'b1;
            acc_q   <= '0;
            n_q     <= '0;
          end else begin
            acc_q <= sum_c;
            n_q   <= n_q + NW'(1);
          end
          if (!i_en) begin
            acc_q <= '0;
            n_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cnv       = cnv_q;
  assign bus.o_spi_start = start_q;
  assign bus.o_adc_data  = data_q;
  assign bus.o_adc_valid = valid_q;
  assign bus.o_overrun   = ovr_q;
  assign bus.o_timeout   = to_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_ad7903_acq_ctrl.sv
// Directed bench for ad7903_acq_ctrl: two instances (4-sample and no averaging)
// each behind a small SPI-master model, with a per-instance result scoreboard.
module tb_ad7903_acq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;

  always #5 clk = ~clk;

  ad7903_acq_ctrl_if #(.DATA_WIDTH(16)) if0 ();
  ad7903_acq_ctrl_if #(.DATA_WIDTH(16)) if1 ();

  ad7903_acq_ctrl dut0 (.i_clk(clk), .i_rst(rst_n), .i_en(en0), .bus(if0.master));
  ad7903_acq_ctrl #(.AVG_LOG2(0)) dut1 (.i_clk(clk), .i_rst(rst_n), .i_en(en1), .bus(if1.master));

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wq0[$];
  logic [15:0] wq1[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  // SPI master models: busy for lat cycles after a start, then idle with data
  logic [2:0]  st0 = '0, st1 = '0;
  logic [15:0] md0 = '0, md1 = '0;
  int          cnt0 = 0, cnt1 = 0;
  int          lat0 = 10, lat1 = 10;
  bit          stuck0 = 1'b0;
  bit          dead0 = 1'b0;

  assign if0.i_spi_state = st0;
  assign if0.i_miso_data = md0;
  assign if1.i_spi_state = st1;
  assign if1.i_miso_data = md1;

  always @(posedge clk) begin
    if (if0.o_spi_start) begin
      st0 <= 3'd2;
      cnt0 <= lat0;
      dead0 <= stuck0;
    end else if (st0 != 3'd0) begin
      if (dead0) begin
        if (!stuck0) st0 <= 3'd0;
      end else if (cnt0 <= 1) begin
        st0 <= 3'd0;
        md0 <= (wq0.size() > 0) ? wq0.pop_front() : 16'hDEAD;
      end else begin
        cnt0 <= cnt0 - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (if1.o_spi_start) begin
      st1 <= 3'd2;
      cnt1 <= lat1;
    end else if (st1 != 3'd0) begin
      if (cnt1 <= 1) begin
        st1 <= 3'd0;
        md1 <= (wq1.size() > 0) ? wq1.pop_front() : 16'hDEAD;
      end else begin
        cnt1 <= cnt1 - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid strobe must match the oldest expected average
  logic [31:0] e0, e1;
  always @(negedge clk) begin
    if (if0.o_adc_valid) begin
      e0 = (exp0.size() > 0) ? 32'(exp0.pop_front()) : 32'hFFFF_FFFF;
      chk("dut0_adc_data", 32'(if0.o_adc_data), e0);
    end
    if (if1.o_adc_valid) begin
      e1 = (exp1.size() > 0) ? 32'(exp1.pop_front()) : 32'hFFFF_FFFF;
      chk("dut1_adc_data", 32'(if1.o_adc_data), e1);
    end
  end

  function automatic bit ev(input bit d, input int w);
    case (w)
      0:       ev = d ? if1.o_spi_start : if0.o_spi_start;
      1:       ev = d ? if1.o_adc_valid : if0.o_adc_valid;
      2:       ev = d ? if1.o_timeout   : if0.o_timeout;
      default: ev = d ? if1.o_cnv       : if0.o_cnv;
    endcase
  endfunction

  function automatic logic [31:0] outs(input bit d);
    if (d) outs = 32'({if1.o_cnv, if1.o_spi_start, if1.o_adc_valid, if1.o_overrun,
                       if1.o_timeout, if1.o_busy, if1.o_adc_data});
    else   outs = 32'({if0.o_cnv, if0.o_spi_start, if0.o_adc_valid, if0.o_overrun,
                       if0.o_timeout, if0.o_busy, if0.o_adc_data});
  endfunction

  // Bounded wait: n = negedges elapsed until the event is seen (or lim)
  task automatic wait_ev(input bit d, input int w, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ev(d, w) && (n < lim));
  endtask

  initial begin
    int n, len, k, ko, vc, oc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs_dut0", outs(1'b0), 32'h0);
    chk("reset_outs_dut1", outs(1'b1), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4-sample average of 0x100..0x400
    lat0 = 10;
    wq0.push_back(16'h0100); wq0.push_back(16'h0200);
    wq0.push_back(16'h0300); wq0.push_back(16'h0400);
    exp0.push_back(16'h0280);
    en0 = 1'b1;
    wait_ev(1'b0, 3, 5, n);
    chk("cnv_rise_latency", 32'(n), 32'd1);
    len = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!if0.o_cnv) break;
      len++;
    end
    chk("cnv_high_cycles", 32'(len), 32'd100);
    chk("start_after_cnv", 32'(if0.o_spi_start), 32'd1);
    chk("busy_in_start", 32'(if0.o_busy), 32'd1);
    wait_ev(1'b0, 0, 400, n);
    chk("start_period", 32'(n), 32'd200);
    wait_ev(1'b0, 0, 400, n);
    wait_ev(1'b0, 0, 400, n);
    wait_ev(1'b0, 1, 100, n);
    chk("avg_valid_seen", 32'(ev(1'b0, 1)), 32'd1);
    en0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("data_hold", 32'(if0.o_adc_data), 32'h0280);
    chk("idle_not_busy", 32'(if0.o_busy), 32'd0);

    // Negative average floors: (-1-1-1+0)/4 -> -1
    wq0.push_back(16'hFFFF); wq0.push_back(16'hFFFF);
    wq0.push_back(16'hFFFF); wq0.push_back(16'h0000);
    exp0.push_back(16'hFFFF);
    en0 = 1'b1;
    wait_ev(1'b0, 1, 1200, n);
    chk("floor_valid_seen", 32'(ev(1'b0, 1)), 32'd1);
    en0 = 1'b0;
    repeat (10) @(negedge clk);

    // SPI stuck busy -> watchdog, then recovery on a later tick
    stuck0 = 1'b1;
    en0 = 1'b1;
    wait_ev(1'b0, 0, 300, n);
    chk("stuck_start_latency", 32'(n), 32'd101);
    oc = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (if0.o_overrun) oc++;
    end while (!if0.o_timeout && (n < 400));
    chk("timeout_cycle", 32'(n), 32'd256);
    chk("timeout_idle", 32'(if0.o_busy), 32'd0);
    chk("stuck_overrun_count", 32'(oc), 32'd1);
    stuck0 = 1'b0;
    wq0.push_back(16'h0010); wq0.push_back(16'h0020);
    wq0.push_back(16'h0030); wq0.push_back(16'h0040);
    exp0.push_back(16'h0028);
    wait_ev(1'b0, 0, 400, n);
    chk("recover_start", 32'(n), 32'd144);
    wait_ev(1'b0, 1, 1000, n);
    chk("recover_valid_seen", 32'(ev(1'b0, 1)), 32'd1);
    en0 = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-WAIT_DONE
    lat0 = 100;
    en0 = 1'b1;
    wait_ev(1'b0, 0, 300, n);
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(if0.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(1'b0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ev(1'b0, 3, 5, n);
    chk("cnv_after_reset", 32'(n), 32'd1);
    en0 = 1'b0;
    repeat (400) @(negedge clk);

    // No averaging: sign preserved, valid in the cycle after CAPTURE
    lat1 = 10;
    wq1.push_back(16'h8000); wq1.push_back(16'h7FFF);
    exp1.push_back(16'h8000); exp1.push_back(16'h7FFF);
    en1 = 1'b1;
    wait_ev(1'b1, 0, 300, n);
    wait_ev(1'b1, 1, 50, n);
    chk("valid_latency", 32'(n), 32'd13);
    wait_ev(1'b1, 1, 300, n);
    chk("second_valid_seen", 32'(ev(1'b1, 1)), 32'd1);
    en1 = 1'b0;
    repeat (10) @(negedge clk);

    // Read stretched past the period: one overrun, one capture per two periods
    lat1 = 250;
    wq1.push_back(16'h0AAA); wq1.push_back(16'h0BBB);
    exp1.push_back(16'h0AAA); exp1.push_back(16'h0BBB);
    en1 = 1'b1;
    ko = 0; vc = 0; oc = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (if1.o_overrun) begin
        ko = i;
        oc++;
      end
      if (if1.o_adc_valid) vc++;
    end
    chk("overrun_cycle", 32'(ko), 32'd201);
    chk("overrun_count", 32'(oc), 32'd1);
    chk("captures_in_two_periods", 32'(vc), 32'd1);
    wait_ev(1'b1, 1, 500, n);
    chk("stretched_second_valid", 32'(ev(1'b1, 1)), 32'd1);
    en1 = 1'b0;
    repeat (5) @(negedge clk);

    chk("sb0_drained", 32'(exp0.size()), 32'd0);
    chk("sb1_drained", 32'(exp1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad7903_acq_ctrl.md
Name: ad7903_acq_ctrl

Overview:
- Sample-rate sequencer sitting directly upstream of the AD7903 SPI master.
- Periodically drives the ADC CNV pin, waits the conversion time, then starts one SPI read.
- Tracks the SPI master state to know when the read has finished, and captures the 16-bit two's-complement result.
- Averages 2^AVG_LOG2 results and presents one signed sample with a valid pulse to downstream DSP/register logic.

Parameters:
- DATA_WIDTH, 16, ADC word width; must equal the SPI master DATA_WIDTH.
- SAMPLE_PERIOD, 200, sample period in i_clk cycles (200 x 5 ns = 1 MSPS); minimum CONV_TIME + 64.
- CONV_TIME, 100, number of cycles o_cnv is held high (conversion time).
- AVG_LOG2, 2, log2 of the number of samples averaged per output (0 = no averaging).
- TIMEOUT, 255, maximum cycles allowed for the SPI transaction before it is abandoned.

Ports:
- i_clk, input, 1, system clock (5 ns).
- i_rst, input, 1, reset; asynchronous, active-low.
- i_en, input, 1, acquisition enable (level).
- i_spi_state, input, 3, SPI master state; 0 = idle.
- i_miso_data, input, DATA_WIDTH, SPI master read data; valid when i_spi_state == 0.
- o_cnv, output, 1, ADC CNV pin.
- o_spi_start, output, 1, one-cycle start pulse to the SPI master.
- o_adc_data, output, DATA_WIDTH, signed averaged sample.
- o_adc_valid, output, 1, one-cycle strobe qualifying o_adc_data.
- o_overrun, output, 1, one-cycle pulse when a period tick is missed.
- o_timeout, output, 1, one-cycle pulse when an SPI transaction is abandoned.
- o_busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (i_rst low, asynchronous) forces every output and internal register to 0:
  - FSM to IDLE, period counter to 0, accumulator to 0, sample counter to 0, timeout counter to 0.
- Period counter:
  - Runs while i_en=1 and counts 0..SAMPLE_PERIOD-1, then wraps to 0.
  - It is held at 0 while i_en=0.
  - tick = (counter == 0) && i_en.
- FSM states: IDLE, CONV, START, WAIT_BUSY, WAIT_DONE, CAPTURE.
  - IDLE: on tick, go to CONV.
  - CONV: o_cnv=1 for exactly CONV_TIME cycles, then go to START. o_cnv is registered, so it rises in the cycle after tick.
  - START: o_spi_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: when i_spi_state != 0, go to WAIT_DONE.
  - WAIT_DONE: when i_spi_state == 0, go to CAPTURE.
  - CAPTURE: latch i_miso_data and accumulate (one cycle), then go to IDLE.
- Timeout counter:
  - Cleared on entry to WAIT_BUSY; increments in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT, pulse o_timeout, go to IDLE, and discard the sample. The accumulator and sample counter are unchanged.
- Overrun: a tick arriving while FSM != IDLE pulses o_overrun for one cycle and is otherwise ignored. Acquisition resumes at the next tick.
- Accumulation:
  - Sample is sign-extended to DATA_WIDTH+AVG_LOG2 bits and added to the accumulator.
  - The sample counter (AVG_LOG2 bits) increments.
  - When the counter wraps (2^AVG_LOG2 samples taken):
    - o_adc_data <= (acc + sample) >>> AVG_LOG2, arithmetic shift, truncating toward minus infinity.
    - o_adc_valid=1 for one cycle.
    - Accumulator cleared.
  - AVG_LOG2=0: every capture produces valid, with o_adc_data equal to the sample.
- Latency: o_adc_valid is asserted in the cycle after CAPTURE. o_adc_data holds its value until the next valid strobe.
- i_en falling mid-transaction:
  - The current transaction completes normally, including capture and any due output.
  - Then the FSM goes to IDLE, and the accumulator and sample counter clear.
  - No new tick is generated while i_en=0.
- i_en rising: first tick occurs in the same cycle (counter is 0).
- Simultaneous events: the timeout check has priority over the state-change condition in the same cycle.
- Overflow: the accumulator cannot overflow by construction (DATA_WIDTH+AVG_LOG2 bits).

Test Plan:
- Default params with an SPI-master model returning 0x0100, 0x0200, 0x0300, 0x0400 -> one o_adc_valid with o_adc_data=0x0280; o_cnv high 100 cycles per sample; o_spi_start pulses every 200 cycles.
- AVG_LOG2=0 with samples 0x8000 then 0x7FFF -> valid each sample, data 0x8000 then 0x7FFF (sign preserved).
- Averaging 0xFFFF, 0xFFFF, 0xFFFF, 0x0000 -> o_adc_data=0xFFFF (-3/4 floors to -1).
- SPI model stuck busy (state=2 forever) -> o_timeout pulses at cycle 255 of the transaction, no valid, FSM back in IDLE; the next tick recovers.
- SPI read stretched to 250 cycles -> o_overrun pulses at the missed tick, and exactly one sample is captured for the two periods.
- Assert i_rst low mid-WAIT_DONE -> all outputs 0 immediately; after release with i_en=1, o_cnv rises on the next clock.
